// File: rtl/apb_xfer_ctrl_if.sv
// apb_xfer_ctrl_if: request/response handshake plus APB bus signals of the
// APB transfer controller. The pready wire exists only when APB_PREADY_EN is
// defined. Modport "master" is the controller's view (it masters the APB
// bus and answers requests); modport "slave" is the environment's view.
interface apb_xfer_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [2:0]        psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] pr_data;
`ifdef APB_PREADY_EN
    logic              pready;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, pr_data, pready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, pr_data, pready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               psel, penable, pwrite, paddr, pwdata
    );
`else
    modport master (
        input  req_valid, req_write, req_addr, req_wdata, pr_data,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, pr_data,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               psel, penable, pwrite, paddr, pwdata
    );
`endif
endinterface

// File: rtl/apb_xfer_ctrl.sv
// apb_xfer_ctrl: sequences single read/write requests onto APB.
// Decodes the address into one of three regions above BASE_ADDR, drives the
// SETUP and ACCESS phases and returns a one-cycle response with error flag.
// Optional feature macro: APB_PREADY_EN (adds pready wait states with a
// TIMEOUT-cycle limit on the ACCESS phase).
module apb_xfer_ctrl #(
    parameter int              ADDR_W       = 32,
    parameter int              DATA_W       = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(32'h8000_0000),
    parameter int              REGION_SHIFT = 26,
    parameter int              TIMEOUT      = 16
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    apb_xfer_ctrl_if.master       bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_ERR    = 2'd3;

    // TIMEOUT must fit the 8-bit wait counter and allow at least one wait.
    if ((TIMEOUT < 2) || (TIMEOUT > 255)) begin : g_bad_timeout
        $error("apb_xfer_ctrl: TIMEOUT out of range 2..255");
    end

    logic [1:0]        state_q,     state_d;
    logic [2:0]        psel_q,      psel_d;
    logic              penable_q,   penable_d;
    logic              pwrite_q,    pwrite_d;
    logic [ADDR_W-1:0] paddr_q,     paddr_d;
    logic [DATA_W-1:0] pwdata_q,    pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q,   rsp_err_d;
`ifdef APB_PREADY_EN
    logic [7:0]        tmo_cnt_q,   tmo_cnt_d;
`endif

    logic [ADDR_W-1:0] off_s;
    logic [ADDR_W-1:0] idx_s;
    logic              in_win_s;
    logic [2:0]        sel_s;

    // Region decode: no wrap-around below BASE_ADDR, only regions 0..2 valid.
    always_comb begin
        off_s    = bus.req_addr - BASE_ADDR;
        idx_s    = off_s >> REGION_SHIFT;
        in_win_s = (bus.req_addr >= BASE_ADDR) && (idx_s < ADDR_W'(32'd3));
        case (idx_s[1:0])
            2'd0:    sel_s = 3'b001;
            2'd1:    sel_s = 3'b010;
            2'd2:    sel_s = 3'b100;
            default: sel_s = 3'b000;
        endcase
    end

    // Next-state and next-output logic of the transfer sequencer.
    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef APB_PREADY_EN
        tmo_cnt_d   = tmo_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                psel_d    = 3'b000;
                penable_d = 1'b0;
                if (bus.req_valid) begin
                    if (in_win_s) begin
                        state_d  = ST_SETUP;
                        psel_d   = sel_s;
                        pwrite_d = bus.req_write;
                        paddr_d  = bus.req_addr;
                        pwdata_d = bus.req_wdata;
                    end else begin
                        state_d  = ST_ERR;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
`ifdef APB_PREADY_EN
                tmo_cnt_d = 8'd0;
`endif
            end
            ST_ACCESS: begin
`ifdef APB_PREADY_EN
                if (bus.pready) begin
                    state_d     = ST_IDLE;
                    psel_d      = 3'b000;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? {DATA_W{1'b0}} : bus.pr_data;
                    rsp_err_d   = 1'b0;
                end else if (tmo_cnt_q == 8'(TIMEOUT - 1)) begin
                    // Last allowed wait cycle expired: abort with error.
                    state_d     = ST_IDLE;
                    psel_d      = 3'b000;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = {DATA_W{1'b0}};
                    rsp_err_d   = 1'b1;
                end else begin
                    tmo_cnt_d   = tmo_cnt_q + 8'd1;
                end
`else
                state_d     = ST_IDLE;
                psel_d      = 3'b000;
                penable_d   = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = pwrite_q ? {DATA_W{1'b0}} : bus.pr_data;
                rsp_err_d   = 1'b0;
`endif
            end
            ST_ERR: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = {DATA_W{1'b0}};
                rsp_err_d   = 1'b1;
            end
            default: begin
                state_d   = ST_IDLE;
                psel_d    = 3'b000;
                penable_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state_q     <= ST_IDLE;
            psel_q      <= 3'b000;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= {ADDR_W{1'b0}};
            pwdata_q    <= {DATA_W{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= {DATA_W{1'b0}};
            rsp_err_q   <= 1'b0;
`ifdef APB_PREADY_EN
            tmo_cnt_q   <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef APB_PREADY_EN
            tmo_cnt_q   <= tmo_cnt_d;
`endif
        end
    end

    // req_ready is the only combinational output.
    assign bus.req_ready = (state_q == ST_IDLE) && hresetn;
    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_xfer_ctrl.sv
// tb_apb_xfer_ctrl: directed self-checking bench for apb_xfer_ctrl.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_apb_xfer_ctrl;

    logic hclk;
    logic hresetn;
    int   total_cnt;
    int   bad_cnt;

    apb_xfer_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

    apb_xfer_ctrl #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .BASE_ADDR    (32'h8000_0000),
        .REGION_SHIFT (26),
        .TIMEOUT      (4)
    ) dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .bus     (bus_if)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    // Present a request for one edge, then drop it; leaves DUT after accept.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
        bus_if.req_valid = 1'b1;
        bus_if.req_write = wr;
        bus_if.req_addr  = addr;
        bus_if.req_wdata = wd;
        tick();
        bus_if.req_valid = 1'b0;
    endtask

    // Read at addr; expect psel sel and response data rd.
    task automatic do_read(input logic [31:0] addr, input logic [2:0] sel, input logic [31:0] rd);
        bus_if.pr_data = rd;
        issue(1'b0, addr, 32'h0);
        chk("rd_psel", bus_if.psel, sel);
        chk("rd_pwrite", bus_if.pwrite, 1'b0);
        tick();
        chk("rd_penable", bus_if.penable, 1'b1);
        tick();
        chk("rd_rsp_valid", bus_if.rsp_valid, 1'b1);
        chk("rd_rdata", bus_if.rsp_rdata, rd);
        chk("rd_err", bus_if.rsp_err, 1'b0);
        chk("rd_psel_off", bus_if.psel, 3'b000);
    endtask

    // Out-of-window request: no psel, error response after one cycle.
    task automatic do_err(input logic [31:0] addr);
        issue(1'b0, addr, 32'h0);
        chk("err_psel", bus_if.psel, 3'b000);
        chk("err_ready_low", bus_if.req_ready, 1'b0);
        chk("err_no_rsp_yet", bus_if.rsp_valid, 1'b0);
        tick();
        chk("err_rsp_valid", bus_if.rsp_valid, 1'b1);
        chk("err_rsp_err", bus_if.rsp_err, 1'b1);
        chk("err_rdata", bus_if.rsp_rdata, 32'h0);
        chk("err_psel2", bus_if.psel, 3'b000);
        chk("err_ready_back", bus_if.req_ready, 1'b1);
        tick();
        chk("err_rsp_drop", bus_if.rsp_valid, 1'b0);
    endtask

`ifdef APB_PREADY_EN
    // Read with wait states; pready rises in ACCESS cycle ok_at (0 = never).
    task automatic do_wait(input int ok_at, input int exp_n, input logic exp_err);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        bus_if.pready  = 1'b0;
        bus_if.pr_data = 32'h0000_5A5A;
        issue(1'b0, 32'h8000_0040, 32'h0);
        for (int i = 0; i < 20; i++) begin
            if (bus_if.penable) begin
                n++;
                bus_if.pready = (ok_at != 0) && (n >= ok_at);
            end
            tick();
            if (bus_if.rsp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("wait_rsp_seen", 32'(seen), 32'd1);
        chk("wait_access_cycles", n, exp_n);
        chk("wait_rsp_err", bus_if.rsp_err, exp_err);
        chk("wait_rdata", bus_if.rsp_rdata, exp_err ? 32'h0 : 32'h0000_5A5A);
        bus_if.pready = 1'b1;
        tick();
    endtask
`endif

    initial begin
        logic exp_rdy [6];
        int   rsp_cnt;
        total_cnt        = 0;
        bad_cnt          = 0;
        hresetn          = 1'b0;
        bus_if.req_valid = 1'b0;
        bus_if.req_write = 1'b0;
        bus_if.req_addr  = 32'h0;
        bus_if.req_wdata = 32'h0;
        bus_if.pr_data   = 32'h0;
`ifdef APB_PREADY_EN
        bus_if.pready    = 1'b1;
`endif

        // Reset then idle.
        tick();
        tick();
        chk("rst_psel", bus_if.psel, 3'b000);
        chk("rst_penable", bus_if.penable, 1'b0);
        chk("rst_pwrite", bus_if.pwrite, 1'b0);
        chk("rst_paddr", bus_if.paddr, 32'h0);
        chk("rst_pwdata", bus_if.pwdata, 32'h0);
        chk("rst_rsp_valid", bus_if.rsp_valid, 1'b0);
        chk("rst_rdata", bus_if.rsp_rdata, 32'h0);
        chk("rst_err", bus_if.rsp_err, 1'b0);
        chk("rst_ready", bus_if.req_ready, 1'b0);
        hresetn = 1'b1;
        #1;
        chk("idle_ready", bus_if.req_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_psel", bus_if.psel, 3'b000);
            chk("idle_rsp", bus_if.rsp_valid, 1'b0);
        end

        // Write to region 1.
        issue(1'b1, 32'h8400_0010, 32'hDEAD_BEEF);
        chk("wr_psel", bus_if.psel, 3'b010);
        chk("wr_penable0", bus_if.penable, 1'b0);
        chk("wr_paddr", bus_if.paddr, 32'h8400_0010);
        chk("wr_pwdata", bus_if.pwdata, 32'hDEAD_BEEF);
        chk("wr_pwrite", bus_if.pwrite, 1'b1);
        chk("wr_ready_low", bus_if.req_ready, 1'b0);
        tick();
        chk("wr_penable1", bus_if.penable, 1'b1);
        chk("wr_psel_hold", bus_if.psel, 3'b010);
        chk("wr_paddr_hold", bus_if.paddr, 32'h8400_0010);
        chk("wr_no_rsp", bus_if.rsp_valid, 1'b0);
        tick();
        chk("wr_psel_off", bus_if.psel, 3'b000);
        chk("wr_penable_off", bus_if.penable, 1'b0);
        chk("wr_rsp_valid", bus_if.rsp_valid, 1'b1);
        chk("wr_rsp_err", bus_if.rsp_err, 1'b0);
        chk("wr_rdata", bus_if.rsp_rdata, 32'h0);
        tick();
        chk("wr_rsp_drop", bus_if.rsp_valid, 1'b0);
        chk("idle_paddr_hold", bus_if.paddr, 32'h8400_0010);

        // Reads: region 2, region 0, last word of region 2.
        do_read(32'h8800_0004, 3'b100, 32'h0000_00A5);
        tick();
        chk("rdata_hold", bus_if.rsp_rdata, 32'h0000_00A5);
        chk("rsp_drop", bus_if.rsp_valid, 1'b0);
        do_read(32'h8000_0000, 3'b001, 32'h1234_5678);
        tick();
        do_read(32'h8BFF_FFFC, 3'b100, 32'hCAFE_F00D);
        tick();

        // Decode errors: first address past region 2, and just below base.
        do_err(32'h8C00_0000);
        do_err(32'h7FFF_FFFC);

        // Back-to-back with req_valid held: ready low exactly 2 cycles.
        exp_rdy = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        rsp_cnt = 0;
        bus_if.req_valid = 1'b1;
        bus_if.req_write = 1'b1;
        bus_if.req_addr  = 32'h8000_0100;
        bus_if.req_wdata = 32'h0000_0001;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("b2b_ready", bus_if.req_ready, exp_rdy[i]);
            if (bus_if.rsp_valid) rsp_cnt++;
        end
        bus_if.req_valid = 1'b0;
        chk("b2b_rsp_count", rsp_cnt, 2);
        tick();
        tick();

        // Reset during ACCESS aborts with no response.
        issue(1'b1, 32'h8400_0020, 32'h0000_BEEF);
        tick();
        chk("abort_in_access", bus_if.penable, 1'b1);
        hresetn = 1'b0;
        tick();
        chk("abort_psel", bus_if.psel, 3'b000);
        chk("abort_penable", bus_if.penable, 1'b0);
        chk("abort_rsp", bus_if.rsp_valid, 1'b0);
        hresetn = 1'b1;
        tick();
        chk("abort_rsp2", bus_if.rsp_valid, 1'b0);
        chk("abort_ready", bus_if.req_ready, 1'b1);

`ifdef APB_PREADY_EN
        do_wait(3, 3, 1'b0);
        do_wait(0, 4, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
